madd_sequencer: RTL and testbench
=================================

# madd_sequencer

Operand sequencer and result buffer wrapped around the MADD multiply-add unit. Accepts {A,B,C} operand triples over a valid/ready handshake, issues at most one per cycle to MADD, tracks in-flight operations through MADD's fixed latency, and captures each Z into a result FIFO drained by a valid/ready output port. Credit-based issue guarantees that no MADD result is ever dropped under output back-pressure.

## Interface
- W, 32: operand/result width; matches MADD.
- LAT, 1: cycles from A/B/C driven to Z valid (≥1).
- IN_DEPTH, 4: input operand FIFO depth (power of 2, ≥2).
- OUT_DEPTH, 4: result FIFO depth (power of 2, ≥2).
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset; one clock; reset is synchronous and active-low.
- IN_VALID  in  1  operand triple valid.
- IN_READY  out  1  input FIFO not full.
- IN_A, IN_B, IN_C  in  W each  operands; result = IN_A*IN_B+IN_C.
- A, B, C  out  W each  to MADD; zero when not issuing.
- Z  in  W  from MADD.
- OUT_VALID  out  1  result FIFO non-empty.
- OUT_READY  in  1  consumer accepts OUT_Z.
- OUT_Z  out  W  head of result FIFO.
- BUSY  out  1  any entry in input FIFO, in flight, or in result FIFO.

## Operation
- Accept: IN_VALID & IN_READY at a rising edge pushes the triple.
- Credits: credit = OUT_DEPTH − (inflight + result count). Issue in cycle k iff input FIFO non-empty and credit > 0.
- Issue: A/B/C = input FIFO head (combinational from FIFO storage, not from IN_*); pop at the edge ending cycle k; a 1 enters the LAT-deep in-flight valid pipe.
- Capture: Z sampled into result FIFO at the edge ending cycle k+LAT−1 (LAT=1: same edge as pop).
- Drain: OUT_VALID & OUT_READY pops the result FIFO.
- Arithmetic: block performs no arithmetic; results are MADD's, i.e. low W bits of A*B+C, modulo 2^W, wrap-around allowed.
- Ordering: strictly FIFO; results leave in acceptance order.

## Timing
- Reset (RST_N low at an edge): both FIFOs empty, in-flight pipe cleared, credit = OUT_DEPTH. Outputs after reset: IN_READY=1, A=B=C=0, OUT_VALID=0, OUT_Z=0, BUSY=0. Reset mid-operation discards all queued and in-flight work; Z arriving later is ignored.
- Minimum latency: accepted at edge ending cycle t → issued cycle t+1 → OUT_VALID first high in cycle t+1+LAT.
- Throughput: one result/cycle sustained when OUT_READY held high.
- IN_READY depends only on registered input count; no combinational path IN_VALID→IN_READY or OUT_READY→IN_READY.
- Input full: IN_READY=0; a pop in the same cycle does not raise IN_READY until next cycle.
- Output full/back-pressure: credit reaches 0 → issue stalls, A/B/C return to 0; a drain in cycle k frees one credit usable in cycle k+1.
- Simultaneous capture and drain on a full result FIFO: both occur, count unchanged.
- OUT_Z and OUT_VALID stable while OUT_VALID & ~OUT_READY.

## Structure
- Package madd_pkg: W, default depths, LAT, operand_t struct {a,b,c}, credit/count width constants.
- One sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop, full/empty/count), instantiated twice (input: 3W, output: W).
- In-flight valid pipe and credit counter live in madd_sequencer.

## Test plan
- Single op: after reset, push {3,5,7}, OUT_READY=1 → OUT_Z=0x16 with OUT_VALID first high 1+LAT cycles after acceptance; BUSY falls next cycle.
- Streaming: push 32 random triples back-to-back, OUT_READY=1 → 32 results, in order, each equal low 32 bits of A*B+C, no bubbles after first.
- Back-pressure: OUT_READY=0, push 10 triples → exactly OUT_DEPTH results held, A/B/C=0 once credit=0, IN_READY drops after IN_DEPTH more; release OUT_READY → all 10 in order, none lost.
- Wrap-around: {0xFFFFFFFF,0xFFFFFFFF,0xFFFFFFFF} → OUT_Z=0x00000000.
- Full-FIFO simultaneity: result FIFO full, OUT_READY pulsed 1 cycle while issue pending → exactly one pop, one new issue the next cycle, count stays OUT_DEPTH.
- Mid-op reset: 3 triples in flight, RST_N low one edge → OUT_VALID=0, BUSY=0, IN_READY=1, A=B=C=0 next cycle; no stale result ever appears.

Source files
------------

// File: rtl/madd_pkg.sv
// madd_pkg: shared constants and types for the MADD operand sequencer.
//   MADD_W          operand/result width of the MADD unit
//   MADD_LAT        MADD latency (A/B/C driven -> Z valid), >= 1
//   IN_DEPTH_DEF    default operand FIFO depth (power of 2)
//   OUT_DEPTH_DEF   default result FIFO depth (power of 2)
//   operand_t       one {a,b,c} operand triple
//   cnt_w()         bits needed to hold an occupancy count 0..depth
package madd_pkg;

   localparam int unsigned MADD_W        = 32;
   localparam int unsigned MADD_LAT      = 1;
   localparam int unsigned IN_DEPTH_DEF  = 4;
   localparam int unsigned OUT_DEPTH_DEF = 4;

   typedef struct packed {
      logic [MADD_W-1:0] a;
      logic [MADD_W-1:0] b;
      logic [MADD_W-1:0] c;
   } operand_t;

   // Occupancy counters must represent the value "depth" itself, hence depth+1.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   localparam int unsigned IN_CNT_W  = cnt_w(IN_DEPTH_DEF);
   localparam int unsigned OUT_CNT_W = cnt_w(OUT_DEPTH_DEF);

endpackage

// File: rtl/madd_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write request/data (accepted when not full, or full with pop)
//   pop          read request (ignored when empty)
//   rdata        head entry; zero while empty
//   full, empty, count  occupancy status, all derived from the registered count
module sync_fifo
   import madd_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = cnt_w(DEPTH),
   localparam int unsigned PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign do_pop_s  = pop & ~empty;
   // A full FIFO can still take a write when the head leaves on the same edge.
   assign do_push_s = push & (~full | do_pop_s);

   // Head read; forced to zero while empty so stale storage never shows.
   always_comb begin
      rdata = {WIDTH{1'b0}};
      if (!empty) begin
         rdata = mem_r[rd_ptr_r];
      end else begin
         rdata = {WIDTH{1'b0}};
      end
   end

   // Storage write; contents need no reset because the count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/madd_sequencer.sv
// madd_sequencer: operand queue, credit-based issue and result buffer around MADD.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operand triple handshake (in_a, in_b, in_c)
//   a, b, c                    operands to MADD; zero in cycles with no issue
//   z                          MADD result, valid LAT cycles after a/b/c
//   out_valid/out_ready/out_z  result handshake, head of the result FIFO
//   busy                       work queued, in flight, or awaiting drain
module madd_sequencer
   import madd_pkg::*;
#(
   parameter int unsigned W         = MADD_W,
   parameter int unsigned LAT       = MADD_LAT,
   parameter int unsigned IN_DEPTH  = IN_DEPTH_DEF,
   parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] c,
   input  logic [W-1:0] z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_z,
   output logic         busy
);

   localparam int unsigned ICW = cnt_w(IN_DEPTH);
   localparam int unsigned OCW = cnt_w(OUT_DEPTH);
   localparam logic [OCW-1:0] CREDIT_INIT = OCW'(OUT_DEPTH);
   localparam logic [OCW-1:0] CREDIT_ONE  = OCW'(1'b1);

   logic [3*W-1:0] head_s;
   logic           in_full_s;
   logic           in_empty_s;
   logic [ICW-1:0] in_count_s;
   logic           out_full_s;
   logic           out_empty_s;
   logic [OCW-1:0] out_count_s;
   logic           push_s;
   logic           issue_s;
   logic           capture_s;
   logic           drain_s;
   logic           inflight_any_s;
   logic [OCW-1:0] credit_r;
   logic           unused_ok_s;

   // in_ready comes only from the registered input count: no path from in_valid/out_ready.
   assign in_ready  = ~in_full_s;
   assign push_s    = in_valid & in_ready;
   assign issue_s   = ~in_empty_s & (credit_r != {OCW{1'b0}});
   assign out_valid = ~out_empty_s;
   assign drain_s   = out_valid & out_ready;
   assign busy      = ~in_empty_s | inflight_any_s | ~out_empty_s;

   // Result FIFO occupancy is covered by the credit counter instead.
   assign unused_ok_s = ^{in_count_s, out_full_s, out_count_s};

   sync_fifo #(.WIDTH(3*W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (issue_s),
      .wdata ({in_a, in_b, in_c}),
      .rdata (head_s),
      .full  (in_full_s),
      .empty (in_empty_s),
      .count (in_count_s)
   );

   sync_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture_s),
      .pop   (drain_s),
      .wdata (z),
      .rdata (out_z),
      .full  (out_full_s),
      .empty (out_empty_s),
      .count (out_count_s)
   );

   // Operand drive to MADD straight from FIFO storage, zero on idle cycles.
   always_comb begin
      a = {W{1'b0}};
      b = {W{1'b0}};
      c = {W{1'b0}};
      if (issue_s) begin
         a = head_s[3*W-1 -: W];
         b = head_s[2*W-1 -: W];
         c = head_s[W-1:0];
      end else begin
         a = {W{1'b0}};
         b = {W{1'b0}};
         c = {W{1'b0}};
      end
   end

   // Credits = free result slots not yet promised to an issued operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_r <= CREDIT_INIT;
      end else begin
         case ({issue_s, drain_s})
            2'b10:   credit_r <= credit_r - CREDIT_ONE;
            2'b01:   credit_r <= credit_r + CREDIT_ONE;
            default: credit_r <= credit_r;
         endcase
      end
   end

   // Z is sampled LAT-1 edges after the issue cycle; LAT=1 means the issue edge itself.
   generate
      if (LAT == 1) begin : g_lat1
         assign capture_s      = issue_s;
         assign inflight_any_s = 1'b0;
      end else begin : g_latn
         logic [LAT-2:0] pipe_r;

         // In-flight valid pipe; reset drops every pending capture.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pipe_r <= {(LAT-1){1'b0}};
            end else begin
               pipe_r[0] <= issue_s;
               for (int i = 1; i < LAT - 1; i++) begin
                  pipe_r[i] <= pipe_r[i-1];
               end
            end
         end

         assign capture_s      = pipe_r[LAT-2];
         assign inflight_any_s = |pipe_r;
      end
   endgenerate

endmodule

// File: tb/tb_madd_sequencer.sv
// Self-checking bench for madd_sequencer with a combinational (LAT=1) MADD model.
module tb_madd_sequencer;
   import madd_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b, in_c;
   logic [W-1:0] a, b, c, z;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int cyc    = 0;
   int first_pop_cyc = -1;
   int last_pop_cyc  = -1;
   logic [W-1:0] sb [$];

   // MADD model with LAT=1: Z valid in the same cycle as A/B/C.
   assign z = a * b + c;

   always #5 clk = ~clk;

   madd_sequencer #(.W(W), .LAT(1), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .a(a), .b(b), .c(c), .z(z),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
   );

   function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] w);
      return x * y + w;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every output transfer pops and compares the oldest expected result.
   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got %h required none", out_z);
         end else begin
            exp_v = sb.pop_front();
            if (out_z !== exp_v) begin
               errors++;
               $display("FAIL result got %h required %h", out_z, exp_v);
            end
         end
         pops++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                       input logic [W-1:0] exp_v);
      bit done = 1'b0;
      in_a = ta; in_b = tb_; in_c = tc; in_valid = 1'b1;
      for (int n = 0; n < 60 && !done; n++) begin
         if (in_ready === 1'b1) begin
            sb.push_back(exp_v);
            done = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL accept_timeout got 0 required 1");
      end
   endtask

   task automatic wait_drain;
      for (int n = 0; n < 300 && sb.size() != 0; n++) tick();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d required 0", sb.size());
      end
   endtask

   task automatic test_reset;
      in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
      checks++; if (a !== 32'h0 || b !== 32'h0 || c !== 32'h0) begin errors++; $display("FAIL rst_abc got %h %h %h required 0", a, b, c); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
      checks++; if (out_z !== 32'h0)    begin errors++; $display("FAIL rst_out_z got %h required 0", out_z); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      in_a = 32'd3; in_b = 32'd5; in_c = 32'd7; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b required 1", in_ready); end
      sb.push_back(32'h16);
      tick();                       // accepted at this edge
      in_valid = 1'b0;
      checks++; if (a !== 32'd3 || b !== 32'd5 || c !== 32'd7) begin errors++; $display("FAIL single_issue got %h %h %h required 3 5 7", a, b, c); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b required 0", out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b required 1", busy); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b required 1", out_valid); end
      tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b valid=%b required 0 0", busy, out_valid); end
   endtask

   task automatic test_stream;
      int p0 = pops;
      logic [W-1:0] ra, rb, rc;
      out_ready = 1'b1;
      first_pop_cyc = -1;
      for (int i = 0; i < 32; i++) begin
         ra = $urandom(); rb = $urandom(); rc = $urandom();
         send(ra, rb, rc, madd(ra, rb, rc));
      end
      wait_drain();
      checks++; if (pops - p0 != 32) begin errors++; $display("FAIL stream_count got %0d required 32", pops - p0); end
      checks++; if (last_pop_cyc - first_pop_cyc != 31) begin errors++; $display("FAIL stream_bubbles got span %0d required 31", last_pop_cyc - first_pop_cyc); end
   endtask

   task automatic test_backpressure;
      int p0 = pops;
      int idx = 0;
      logic [W-1:0] ta [10];
      logic [W-1:0] tb_ [10];
      logic [W-1:0] tc [10];
      for (int i = 0; i < 10; i++) begin
         ta[i] = $urandom(); tb_[i] = $urandom(); tc[i] = $urandom();
      end
      out_ready = 1'b0;
      for (int n = 0; n < 15; n++) begin
         if (idx < 10) begin
            in_a = ta[idx]; in_b = tb_[idx]; in_c = tc[idx]; in_valid = 1'b1;
            if (in_ready === 1'b1) begin
               sb.push_back(madd(ta[idx], tb_[idx], tc[idx]));
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      checks++; if (idx != 8) begin errors++; $display("FAIL bp_accepted got %0d required 8", idx); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
      checks++; if (a !== 32'h0 || b !== 32'h0 || c !== 32'h0) begin errors++; $display("FAIL bp_abc_stall got %h %h %h required 0", a, b, c); end
      checks++; if (out_valid !== 1'b1 || out_z !== sb[0]) begin errors++; $display("FAIL bp_head got %b/%h required 1/%h", out_valid, out_z, sb[0]); end
      out_ready = 1'b1;
      for (int n = 0; n < 60 && idx < 10; n++) begin
         in_a = ta[idx]; in_b = tb_[idx]; in_c = tc[idx]; in_valid = 1'b1;
         if (in_ready === 1'b1) begin
            sb.push_back(madd(ta[idx], tb_[idx], tc[idx]));
            idx++;
         end
         tick();
      end
      in_valid = 1'b0;
      wait_drain();
      checks++; if (pops - p0 != 10) begin errors++; $display("FAIL bp_drained got %0d required 10", pops - p0); end
   endtask

   task automatic test_wrap;
      out_ready = 1'b1;
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      wait_drain();
   endtask

   task automatic test_full_simul;
      int p0 = pops;
      logic [W-1:0] ra [5];
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ra[i] = $urandom_range(1, 1000);
         send(ra[i], 32'd2, 32'd1, madd(ra[i], 32'd2, 32'd1));
      end
      tick(); tick(); tick();
      checks++; if (a !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL fs_stalled got a=%h valid=%b required 0 1", a, out_valid); end
      out_ready = 1'b1;
      checks++; if (a !== 32'h0) begin errors++; $display("FAIL fs_same_cycle_issue got %h required 0", a); end
      tick();
      out_ready = 1'b0;
      checks++; if (a !== ra[4]) begin errors++; $display("FAIL fs_next_issue got %h required %h", a, ra[4]); end
      tick();
      checks++; if (a !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL fs_refull got a=%h valid=%b required 0 1", a, out_valid); end
      out_ready = 1'b1;
      wait_drain();
      checks++; if (pops - p0 != 5) begin errors++; $display("FAIL fs_drained got %0d required 5", pops - p0); end
   endtask

   task automatic test_midop_reset;
      bit stale = 1'b0;
      out_ready = 1'b0;
      send(32'd11, 32'd12, 32'd13, madd(32'd11, 32'd12, 32'd13));
      send(32'd21, 32'd22, 32'd23, madd(32'd21, 32'd22, 32'd23));
      send(32'd31, 32'd32, 32'd33, madd(32'd31, 32'd32, 32'd33));
      rst_n = 1'b0;
      sb.delete();
      tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b required 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b required 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b required 1", in_ready); end
      checks++; if (a !== 32'h0 || b !== 32'h0 || c !== 32'h0) begin errors++; $display("FAIL mr_abc got %h %h %h required 0", a, b, c); end
      out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      checks++; if (stale) begin errors++; $display("FAIL mr_stale got 1 required 0"); end
      send(32'd2, 32'd3, 32'd4, 32'd10);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_full_simul();
      test_midop_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1);
   end

endmodule
